// File: rtl/laser_tape_player.sv
// Cassette playback engine: buffers tape bytes in a small FIFO and serialises
// each byte MSB-first as square-wave cycles (bit-1 = two short cycles, bit-0 = one long cycle).
module laser_tape_player #(
    parameter int HALF_SHORT = 1638,
    parameter int HALF_LONG  = 3276,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        F14M,
    input  logic        reset_n,
    input  logic        play,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        casin,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] byte_count,
    output logic [1:0]  state_dbg
);

    localparam int CW = $clog2(HALF_LONG);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] SHORT_M1 = CW'(HALF_SHORT - 1);
    localparam logic [CW-1:0] LONG_M1  = CW'(HALF_LONG - 1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HIGH = 2'd2, LOW = 2'd3} state_t;

    // Handshake: a byte moves when in_valid && in_ready on a rising edge;
    // in_ready depends only on the FIFO fill level, never on a same-cycle pop.

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   fill_q, fill_d;
    logic          ne_q;
    logic          push, pop;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    cyc_q;
    logic [2:0]    idx_q;
    logic [7:0]    sh_q;
    logic          casin_q, underrun_q;
    logic [15:0]   byte_count_q;
    logic [7:0]    head;
    logic [CW-1:0] half_m1;

    assign in_ready   = (fill_q != FULL_LVL);
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == LOAD);
    assign head       = mem_q[rd_ptr_q];
    assign half_m1    = sh_q[7] ? SHORT_M1 : LONG_M1;

    assign casin      = casin_q;
    assign underrun   = underrun_q;
    assign byte_count = byte_count_q;
    assign busy       = (fill_q != '0) || (state_q != IDLE);
    assign state_dbg  = state_q;

    always_comb begin
        fill_d = fill_q;
        if (push && !pop)
            fill_d = fill_q + (AW+1)'(1);
        else if (pop && !push)
            fill_d = fill_q - (AW+1)'(1);
    end

    always_ff @(posedge F14M) begin
        if (push)
            mem_q[wr_ptr_q] <= in_data;
    end

    // ne_q lags the fill level by a clock, which sets the empty-FIFO start latency.
    always_ff @(posedge F14M or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ne_q     <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            fill_q <= fill_d;
            ne_q   <= (fill_q != '0);
        end
    end

    always_ff @(posedge F14M or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cyc_q        <= 2'd0;
            idx_q        <= 3'd0;
            sh_q         <= 8'h00;
            casin_q      <= 1'b0;
            underrun_q   <= 1'b0;
            byte_count_q <= 16'h0000;
        end else begin
            underrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    casin_q <= 1'b0;
                    if (play && ne_q)
                        state_q <= LOAD;
                end
                LOAD: begin
                    sh_q    <= head;
                    idx_q   <= 3'd7;
                    cyc_q   <= head[7] ? 2'd2 : 2'd1;
                    cnt_q   <= head[7] ? SHORT_M1 : LONG_M1;
                    casin_q <= 1'b1;
                    state_q <= HIGH;
                end
                HIGH: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        cnt_q   <= half_m1;
                        casin_q <= 1'b0;
                        state_q <= LOW;
                    end
                end
                LOW: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (cyc_q == 2'd2) begin
                        cyc_q   <= 2'd1;
                        cnt_q   <= half_m1;
                        casin_q <= 1'b1;
                        state_q <= HIGH;
                    end else if (idx_q != 3'd0) begin
                        sh_q    <= {sh_q[6:0], 1'b0};
                        idx_q   <= idx_q - 3'd1;
                        cyc_q   <= sh_q[6] ? 2'd2 : 2'd1;
                        cnt_q   <= sh_q[6] ? SHORT_M1 : LONG_M1;
                        casin_q <= 1'b1;
                        state_q <= HIGH;
                    end else begin
                        // Byte finished; play is only sampled here and in IDLE.
                        byte_count_q <= byte_count_q + 16'd1;
                        if (play && ne_q) begin
                            state_q <= LOAD;
                        end else begin
                            underrun_q <= play;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/laser_tape_player.md
# laser_tape_player

Cassette playback engine for the Laser 500 core. It sits directly upstream of the `CASIN` cassette-input latch. It accepts tape image bytes over a valid/ready stream from the loader, buffers them in a small FIFO, and serialises each byte MSB-first into the square-wave pulse encoding the ROM tape routines decode. Its output replaces the UART-derived cassette level feeding the VTL chip and the audio mixer.

## Interface
- `HALF_SHORT`, default 1638: half-period, in F14M cycles, of a bit-1 cycle.
- `HALF_LONG`, default 3276: half-period, in F14M cycles, of a bit-0 cycle. Must equal 2×`HALF_SHORT`.
- `FIFO_DEPTH`, default 4: byte FIFO entries. Power of two, at least 2.
- `F14M` in 1: system clock, 14.77 MHz. All logic is on the rising edge.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `play` in 1: level. Playback is enabled while high.
- `in_data` in 8: tape byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the FIFO can accept a byte.
- `casin` out 1: tape signal level. Idles at 0.
- `busy` out 1: the FIFO is non-empty, or the state is not IDLE.
- `underrun` out 1: one-cycle pulse; a byte finished while `play`=1 and the FIFO was empty.
- `byte_count` out 16: number of bytes fully played. Wraps at 0xFFFF→0.

## Operation
- **Reset.** All outputs are 0 except `in_ready`=1. The FIFO is flushed and the state is IDLE.
- **FIFO.**
  - `in_ready` = not full.
  - A push happens when `in_valid` and `in_ready` are both high.
  - A pop happens only in the LOAD state.
  - When the FIFO is full, `in_ready`=0 even if a pop occurs in the same cycle. There is no same-cycle bypass.
  - A push and a pop in the same cycle on a non-full FIFO leave the occupancy unchanged.
- **Bit encoding.**
  - A bit-1 is 2 cycles, each HIGH for `HALF_SHORT` clocks then LOW for `HALF_SHORT` clocks.
  - A bit-0 is 1 cycle, HIGH for `HALF_LONG` clocks then LOW for `HALF_LONG` clocks.
  - Every bit is therefore 4×`HALF_SHORT` clocks long.
- **State machine.**
  - IDLE: `casin`=0. Go to LOAD when `play`=1 and the FIFO is non-empty.
  - LOAD: lasts 1 clock. Pop the FIFO head into the shift register, set the bit index to 7, and load the cycle count (2 if the MSB is 1, else 1). Then go to HIGH.
  - HIGH: `casin`=1 for exactly the half-period of the current bit. Then go to LOW.
  - LOW: `casin`=0 for exactly the half-period. At its end:
    - If cycles remain for this bit, go to HIGH.
    - Else, if the bit index is >0, shift left, decrement the index, reload the cycle count from the new MSB, and go to HIGH.
    - Else the byte is done: increment `byte_count`. Then go to LOAD if `play`=1 and the FIFO is non-empty. If `play`=1 and the FIFO is empty, pulse `underrun` and go to IDLE. If `play`=0, go to IDLE.
- **`play` deasserted mid-byte.** The current byte completes unchanged. `play` is sampled only in IDLE and at byte end. Bytes still in the FIFO are retained.
- **`reset_n` asserted mid-byte.** The output is immediately `casin`=0, the FIFO is emptied, and `byte_count`=0. No `underrun` pulse is generated.
- **Half-period counter.** Width is `$clog2(HALF_LONG)`. Load it with the half-period minus 1 on entry to HIGH or LOW, and count down to 0.

## Timing
- All outputs are registered.
- **Empty-FIFO start.** The byte is accepted at edge t (IDLE, `play`=1). The FIFO is non-empty at t+1, LOAD occurs at t+2, and `casin` is first 1 in the cycle after edge t+3.
- **Byte duration.**
  - One byte occupies 1 (LOAD) + 32×`HALF_SHORT` clocks.
  - Back-to-back bytes are separated only by the 1-clock LOAD, during which `casin`=0.
  - LOAD follows the final LOW directly, so that LOW effectively lasts half-period+1 clocks.
- **`byte_count` and `underrun`.** Both update on the same edge that leaves the final LOW.
- **`busy`.** Falls in the same cycle IDLE is entered with an empty FIFO.

## Test plan
Parameters for all scenarios: `HALF_SHORT`=4, `HALF_LONG`=8, `FIFO_DEPTH`=4.
- **Reset values.** Release `reset_n` with `play`=0. Expect `casin`=0, `in_ready`=1, `busy`=0, `byte_count`=0, `underrun`=0.
- **Single byte.** Push 0xA5 with `play`=1.
  - Expect `casin` HIGH 3 edges after the push.
  - Expect the pattern H4 L4 H4 L4 / H8 L8 / H4 L4 H4 L4 / H8 L8 / H8 L8 / H4 L4 H4 L4 / H8 L8 / H4 L4 H4 L4, 128 clocks total.
  - Then `byte_count`=1, one `underrun` pulse, and `busy`=0.
- **FIFO full and back-to-back bytes.**
  - With `play`=0, push 0x00, 0xFF, 0x55, 0x0F. Expect `in_ready`=0 after the 4th push, and a 5th `in_valid` is not accepted.
  - Raise `play`. Expect 4 bytes played with exactly 1 LOW LOAD clock between them, `byte_count`=4, and a single `underrun` pulse.
- **`play` dropped mid-byte.** Drop `play` during bit 3 of 0xC3 while 0x81 is queued.
  - Expect 0xC3 to complete, then IDLE with `busy`=1 (0x81 retained) and no `underrun`.
  - Re-raise `play`. Expect 0x81 to play.
- **Reset mid-byte.** Assert `reset_n`=0 during a HIGH half-period. Expect `casin`=0 asynchronously, the FIFO to be empty, and `byte_count`=0.
- **Counter wrap.** Force `byte_count` to 0xFFFF through a preloaded run and play one byte. Expect `byte_count`=0x0000.
